// File: rtl/fir_sample_feeder.sv
// Sample FIFO and issue controller feeding the folded 8-tap FIR; one registered en/x strobe per filter computation.
// Optional FEEDER_BYPASS_EN: an empty, idle feeder loads the incoming sample straight into flt_x.
module fir_sample_feeder #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     flt_ready,
    output logic                     flt_en,
    output logic [WIDTH-1:0]         flt_x,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             bypass, push, pop;

    assign in_ready = (level != LW'(DEPTH));

`ifdef FEEDER_BYPASS_EN
    assign bypass = !flush && state == IDLE && level == '0 && in_valid && flt_ready;
`else
    assign bypass = 1'b0;
`endif

    // flush wins over both sides; a bypassed sample never touches the FIFO
    assign pop  = !flush && state == IDLE && level != '0 && flt_ready;
    assign push = !flush && in_valid && in_ready && !bypass;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (!push && pop)
                level <= level - 1'b1;
        end
    end

    // WAIT holds off the next issue until the filter has visibly dropped ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            flt_en <= 1'b0;
            flt_x  <= '0;
        end else begin
            flt_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop || bypass) begin
                        flt_en <= 1'b1;
                        flt_x  <= bypass ? in_data : mem[rd_ptr];
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (!flt_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
